alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle controller in front of the 32-bit ALU. It accepts one operation per start/done handshake, registers the operands and opcode that drive the ALU's Y, B and opcode inputs, and holds them stable for a per-class latency. It then captures the 64-bit ALU result, maintaining the architectural HI/LO registers for mul/div and servicing mfhi, mflo, nop and halt without using the ALU.

## Interface
Parameters:
- MUL_CYCLES, default 4: cycles operands are held for mul (opcode 01110). Legal range ≥1.
- DIV_CYCLES, default 8: cycles operands are held for div (opcode 01111). Legal range ≥1.

Ports:
- Clocking (already decided): one clock; reset is synchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
- clk  in  1  sole clock; all state changes on the rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  5  opcode of the request.
- a_in  in  32  first operand (drives Y).
- b_in  in  32  second operand (drives B).
- alu_c  in  64  ALU C output.
- y_out  out  32  registered operand to ALU Y input.
- b_out  out  32  registered operand to ALU B input.
- opcode_out  out  5  registered opcode to ALU.
- busy  out  1  high in EXEC.
- done  out  1  one-cycle pulse; result and flags valid while high.
- result  out  32  registered result.
- hi, lo  out  32 each  architectural HI/LO registers.
- div_zero  out  1  high with done if a div had b_in=0.
- illegal  out  1  high with done for opcodes 11011–11111.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, EXEC, DONE, HALT. A counter cnt holds the remaining EXEC cycles, width clog2(max(MUL_CYCLES,DIV_CYCLES))+1.
- Latency L by opcode:
  - mul: MUL_CYCLES.
  - div: DIV_CYCLES.
  - mfhi (10111), mflo (11000), nop (11001), illegal: L=0.
  - All other opcodes 00000–10110: L=1 (single-cycle ALU class).
- IDLE with start=1 and an L≥1 opcode:
  - Latch y_out=a_in, b_out=b_in, opcode_out=op.
  - Load cnt=L-1 and go to EXEC.
- IDLE with start=1 and an L=0 opcode: go directly to DONE.
  - mfhi: result=hi.
  - mflo: result=lo.
  - nop: result=0.
  - illegal: result=0, illegal=1.
- div with b_in==0 at accept: go directly to DONE with result=0 and div_zero=1. HI/LO are unchanged and the ALU is not exercised.
- halt (11010) accepted: go to HALT. No done pulse. Only clr leaves HALT; start is ignored there.
- EXEC: y_out, b_out and opcode_out are held constant. cnt decrements each edge. On the edge where cnt==0, capture the result and go to DONE:
  - result=alu_c[31:0].
  - mul additionally writes hi=alu_c[63:32] and lo=alu_c[31:0].
  - div additionally writes lo=alu_c[31:0] (quotient) and hi=alu_c[63:32] (remainder).
  - All other opcodes leave HI/LO unchanged.
- DONE: done=1 for exactly one cycle, then return to IDLE. The start input is ignored in DONE; the requester re-asserts start in IDLE.
- div_zero and illegal are valid only while done=1 and are 0 otherwise.
- start, op, a_in and b_in are don't-care outside the IDLE sampling edge.

## Timing
- Reset (clr=1 at an edge): state=IDLE, cnt=0. All outputs are 0: y_out, b_out, opcode_out, result, hi, lo, busy, done, div_zero, illegal, halted. clr overrides every other input in every state, including mid-EXEC and HALT. Any in-flight operation is dropped and produces no done.
- start sampled high at edge t (in IDLE):
  - L≥1: busy is high during cycles t..t+L-1 (between edges), capture occurs at edge t+L, and done is high in the cycle after edge t+L. Request-to-done is L+1 cycles.
  - L=0: done is high in the cycle after edge t.
- Minimum spacing between accepted starts is L+2 edges (an IDLE edge is required after DONE).
- All outputs are registered. There is no combinational path from inputs to outputs.
- alu_c is sampled only at the capture edge. The ALU is treated as a multicycle path of L cycles.

## Test plan
- ADD: a=7, b=5, op=00011. Required: busy for 1 cycle, done 2 cycles after start with result=12. hi/lo stay 0.
- MUL with MUL_CYCLES=4: a=0x10000, b=0x10000. Required: done 5 cycles after start, hi=0x1, lo=0x0, result=0x0. A following mfhi returns 1 with done 1 cycle after start; mflo returns 0.
- DIV with DIV_CYCLES=8: a=100, b=7. Required: done 9 cycles after start, lo=14, hi=2. A follow-up div with b=0 gives done 1 cycle after start with div_zero=1, result=0, and hi/lo unchanged at 2/14.
- Protocol: start held high continuously for a sequence of ADDs. Required: one acceptance per 3 edges; y_out and b_out are stable throughout EXEC even while a_in changes every cycle; done is exactly 1 cycle wide.
- Illegal opcode and nop: op=11100 gives done with illegal=1 and result=0. op=11001 gives done with illegal=0, result=0, and hi/lo unchanged.
- Halt and reset:
  - halt gives halted=1 with no done. A subsequent start is ignored for 10 cycles. clr returns to IDLE with all outputs 0.
  - clr asserted on the 3rd EXEC cycle of a div: no done pulse, hi/lo=0, and the next ADD completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer in front of the 32-bit ALU: holds operands for a per-class
// latency, captures the 64-bit result and keeps the architectural HI/LO registers.
module alu_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        i_start,
  input  logic [4:0]  i_op,
  input  logic [31:0] i_a_in,
  input  logic [31:0] i_b_in,
  input  logic [63:0] i_alu_c,
  output logic [31:0] o_y_out,
  output logic [31:0] o_b_out,
  output logic [4:0]  o_opcode_out,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_div_zero,
  output logic        o_illegal,
  output logic        o_halted
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_LAST = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;
  localparam logic [4:0] OP_ILL  = 5'b11011;

  typedef enum logic [1:0] {IDLE, EXEC, DONE, HALT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_y, r_b, r_result, r_hi, r_lo;
  logic [4:0]    r_opc;
  logic          r_busy, r_done, r_dz, r_ill, r_halted;

  logic          w_is_mul, w_is_div, w_long;
  logic [CW-1:0] w_lat_m1;

  assign w_is_mul = (i_op == OP_MUL);
  assign w_is_div = (i_op == OP_DIV);
  // Anything that keeps the ALU busy; a div by zero is answered without it.
  assign w_long   = w_is_mul || (w_is_div && i_b_in != 32'd0) || (i_op <= OP_LAST && !w_is_div);

  always_comb begin
    w_lat_m1 = '0;
    if (w_is_mul)      w_lat_m1 = CW'(MUL_CYCLES - 1);
    else if (w_is_div) w_lat_m1 = CW'(DIV_CYCLES - 1);
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_y      <= '0;
      r_b      <= '0;
      r_opc    <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_ill    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          if (i_op == OP_HALT) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (w_long) begin
            r_y     <= i_a_in;
            r_b     <= i_b_in;
            r_opc   <= i_op;
            r_cnt   <= w_lat_m1;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end else begin
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_ill    <= (i_op >= OP_ILL);
            r_dz     <= w_is_div;
            r_result <= (i_op == OP_MFHI) ? r_hi :
                        (i_op == OP_MFLO) ? r_lo : 32'd0;
          end
        end
        EXEC: begin
          if (r_cnt == '0) begin
            r_result <= i_alu_c[31:0];
            if (r_opc == OP_MUL || r_opc == OP_DIV) begin
              r_hi <= i_alu_c[63:32];
              r_lo <= i_alu_c[31:0];
            end
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_dz    <= 1'b0;
          r_ill   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= HALT;
      endcase
    end
  end

  assign o_y_out      = r_y;
  assign o_b_out      = r_b;
  assign o_opcode_out = r_opc;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_result     = r_result;
  assign o_hi         = r_hi;
  assign o_lo         = r_lo;
  assign o_div_zero   = r_dz;
  assign o_illegal    = r_ill;
  assign o_halted     = r_halted;
endmodule
